// File: rtl/agg_accum.sv
// agg_accum: multi-lane saturating accumulator with rescale, activation and a
// one-entry output register. Each group of cfg_len beats yields one result per
// lane. The result register is refilled on the same cycle it is consumed.
module agg_accum #(
  parameter int CH    = 4,
  parameter int IN_W  = 12,
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [1:0]            cfg_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*IN_W-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   out_data,
  output logic [CH-1:0]         out_sign,
  output logic [CH-1:0]         out_ovf
);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  localparam logic [1:0] MODE_RELU = 2'd1;
  localparam logic [1:0] MODE_SIGN = 2'd2;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // Output range expressed at accumulator width so the compare is exact.
  localparam logic signed [ACC_W-1:0] OUT_MAX_A = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN_A = ~OUT_MAX_A;
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Clamp a one-bit-wider sum back into the accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1]) begin
      sat_acc = s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_acc = s[ACC_W-1:0];
    end
  endfunction

  // Clamp a rescaled accumulator value into the output range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] s);
    if (s > OUT_MAX_A) begin
      sat_out = OUT_MAX;
    end else if (s < OUT_MIN_A) begin
      sat_out = OUT_MIN;
    end else begin
      sat_out = s[OUT_W-1:0];
    end
  endfunction

  state_t                   state_q, state_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [1:0]               mode_q, mode_d;
  logic signed [ACC_W-1:0]  acc_q [CH];
  logic signed [ACC_W-1:0]  acc_d [CH];
  logic [CH-1:0]            ovf_acc_q, ovf_acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [CH*OUT_W-1:0]      out_data_q, out_data_d;
  logic [CH-1:0]            out_sign_q, out_sign_d;
  logic [CH-1:0]            out_ovf_q, out_ovf_d;

  logic                     first_beat;
  logic                     in_fire;
  logic                     last_beat;
  logic [LEN_W-1:0]         len_eff;
  logic [1:0]               mode_eff;
  logic signed [ACC_W-1:0]  acc_nxt [CH];
  logic [CH-1:0]            ovf_nxt;
  logic [CH*OUT_W-1:0]      res_data;
  logic [CH-1:0]            res_sign;
  logic [CH-1:0]            res_ovf;

  assign in_ready   = ~out_valid_q | out_ready;
  assign in_fire    = in_valid & in_ready;
  assign first_beat = (state_q == S_IDLE);

  // Configuration is sampled on the opening beat of a group and frozen after.
  assign len_eff   = first_beat ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len) : len_q;
  assign mode_eff  = first_beat ? cfg_mode : mode_q;
  assign last_beat = ({1'b0, cnt_q} + (LEN_W+1)'(1)) == {1'b0, len_eff};

  for (genvar i = 0; i < CH; i++) begin : g_lane
    logic signed [IN_W-1:0]  lane_in;
    logic signed [ACC_W:0]   sum;
    logic                    acc_sat;
    logic signed [ACC_W-1:0] acc_new;
    logic signed [ACC_W-1:0] shifted;
    logic signed [OUT_W-1:0] q;
    logic                    out_sat;
    logic                    acc_neg;
    logic                    acc_pos;

    assign lane_in = in_data[i*IN_W +: IN_W];
    assign sum     = (ACC_W+1)'(acc_q[i]) + (ACC_W+1)'(lane_in);
    assign acc_sat = ~first_beat & (sum[ACC_W] != sum[ACC_W-1]);
    assign acc_new = first_beat ? ACC_W'(lane_in) : sat_acc(sum);
    assign ovf_nxt[i] = first_beat ? 1'b0 : (ovf_acc_q[i] | acc_sat);
    assign acc_nxt[i] = acc_new;

    assign shifted = acc_new >>> SHIFT;
    assign q       = sat_out(shifted);
    assign out_sat = (shifted > OUT_MAX_A) || (shifted < OUT_MIN_A);
    assign acc_neg = acc_new[ACC_W-1];
    assign acc_pos = ~acc_neg;

    assign res_sign[i] = acc_neg;
    assign res_data[i*OUT_W +: OUT_W] =
        (mode_eff == MODE_SIGN)                     ? OUT_W'(acc_pos) :
        ((mode_eff == MODE_RELU) && (shifted < 0))  ? '0 :
                                                      q;
    assign res_ovf[i] = (mode_eff == MODE_SIGN) ? ovf_nxt[i] : (ovf_nxt[i] | out_sat);
  end

  // Next-state: group counting, accumulator update and output register load.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sign_d  = out_sign_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      len_d     = len_eff;
      mode_d    = mode_eff;
      acc_d     = acc_nxt;
      ovf_acc_d = ovf_nxt;
      if (last_beat) begin
        cnt_d       = '0;
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        out_data_d  = res_data;
        out_sign_d  = res_sign;
        out_ovf_d   = res_ovf;
      end else begin
        cnt_d   = cnt_q + LEN_W'(1);
        state_d = S_ACCUM;
      end
    end
  end

  // State registers; reset drops any partial group and any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= LEN_W'(1);
      mode_q      <= '0;
      for (int i = 0; i < CH; i++) begin
        acc_q[i] <= '0;
      end
      ovf_acc_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sign_q  <= '0;
      out_ovf_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sign_q  <= out_sign_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sign  = out_sign_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_agg_accum.sv
// Directed bench for agg_accum with hand-computed expectations.
module tb_agg_accum;
  localparam int CH    = 4;
  localparam int IN_W  = 12;
  localparam int ACC_W = 16;
  localparam int OUT_W = 8;
  localparam int SHIFT = 0;
  localparam int LEN_W = 8;

  logic                clk;
  logic                rst;
  logic [LEN_W-1:0]    cfg_len;
  logic [1:0]          cfg_mode;
  logic                in_valid;
  logic                in_ready;
  logic [CH*IN_W-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [CH*OUT_W-1:0] out_data;
  logic [CH-1:0]       out_sign;
  logic [CH-1:0]       out_ovf;

  int compared = 0;
  int mismatched = 0;

  agg_accum #(
    .CH(CH), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sign(out_sign), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CH*IN_W-1:0] pack_in(input int a, input int b, input int c, input int d);
    pack_in = {IN_W'(d), IN_W'(c), IN_W'(b), IN_W'(a)};
  endfunction

  function automatic logic [CH*OUT_W-1:0] pack_out(input int a, input int b, input int c, input int d);
    pack_out = {OUT_W'(d), OUT_W'(c), OUT_W'(b), OUT_W'(a)};
  endfunction

  // One accepted beat (assuming in_ready), then sample 1 time unit after the edge.
  task automatic drive_beat(input int a, input int b, input int c, input int d);
    in_valid = 1'b1;
    in_data  = pack_in(a, b, c, d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = pack_in(5, 5, 5, 5);
    cfg_len = 8'd2; cfg_mode = 2'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    compared++; if (out_data !== 32'h0) begin mismatched++; $display("FAIL reset_data: got %h want 00000000", out_data); end
    compared++; if (out_ovf !== 4'b0) begin mismatched++; $display("FAIL reset_ovf: got %b want 0000", out_ovf); end
    compared++; if (out_sign !== 4'b0) begin mismatched++; $display("FAIL reset_sign: got %b want 0000", out_sign); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    // A beat counted during reset would make this first beat close the group.
    drive_beat(3, 0, 0, 0);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_nocount: got %b want 0", out_valid); end
    drive_beat(4, 0, 0, 0);
    compared++; if (out_data !== pack_out(7, 0, 0, 0)) begin mismatched++; $display("FAIL reset_first_group: got %h want %h", out_data, pack_out(7, 0, 0, 0)); end
  endtask

  task automatic test_relu();
    idle_cycle();
    cfg_len = 8'd3; cfg_mode = 2'd1;
    drive_beat(5, -7, 0, 0);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL relu_beat1_valid: got %b want 0", out_valid); end
    drive_beat(-2, -7, 0, 0);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL relu_beat2_valid: got %b want 0", out_valid); end
    drive_beat(10, -7, 0, 0);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL relu_valid: got %b want 1", out_valid); end
    compared++; if (out_data !== pack_out(13, 0, 0, 0)) begin mismatched++; $display("FAIL relu_data: got %h want %h", out_data, pack_out(13, 0, 0, 0)); end
    compared++; if (out_sign !== 4'b0010) begin mismatched++; $display("FAIL relu_sign: got %b want 0010", out_sign); end
    compared++; if (out_ovf !== 4'b0000) begin mismatched++; $display("FAIL relu_ovf: got %b want 0000", out_ovf); end
    idle_cycle();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL relu_consumed: got %b want 0", out_valid); end
  endtask

  task automatic test_sign();
    idle_cycle();
    cfg_len = 8'd1; cfg_mode = 2'd2;
    drive_beat(-1, 0, 2047, -2048);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL sign_valid: got %b want 1", out_valid); end
    compared++; if (out_data !== pack_out(0, 1, 1, 0)) begin mismatched++; $display("FAIL sign_data: got %h want %h", out_data, pack_out(0, 1, 1, 0)); end
    compared++; if (out_sign !== 4'b1001) begin mismatched++; $display("FAIL sign_sign: got %b want 1001", out_sign); end
    compared++; if (out_ovf !== 4'b0000) begin mismatched++; $display("FAIL sign_ovf: got %b want 0000", out_ovf); end
  endtask

  task automatic test_saturation();
    idle_cycle();
    cfg_len = 8'd20; cfg_mode = 2'd0;
    for (int k = 0; k < 19; k++) drive_beat(2047, -2048, 0, 0);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL sat_early_valid: got %b want 0", out_valid); end
    drive_beat(2047, -2048, 0, 0);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL sat_valid: got %b want 1", out_valid); end
    compared++; if (out_data !== pack_out(127, -128, 0, 0)) begin mismatched++; $display("FAIL sat_data: got %h want %h", out_data, pack_out(127, -128, 0, 0)); end
    compared++; if (out_ovf !== 4'b0011) begin mismatched++; $display("FAIL sat_ovf: got %b want 0011", out_ovf); end
    compared++; if (out_sign !== 4'b0010) begin mismatched++; $display("FAIL sat_sign: got %b want 0010", out_sign); end
    cfg_len = 8'd2;
    drive_beat(60, 0, 0, 0);
    drive_beat(60, 0, 0, 0);
    compared++; if (out_data !== pack_out(120, 0, 0, 0)) begin mismatched++; $display("FAIL sat_fit_data: got %h want %h", out_data, pack_out(120, 0, 0, 0)); end
    compared++; if (out_ovf !== 4'b0000) begin mismatched++; $display("FAIL sat_fit_ovf: got %b want 0000", out_ovf); end
  endtask

  task automatic test_backpressure();
    idle_cycle();
    cfg_len = 8'd1; cfg_mode = 2'd0; out_ready = 1'b0;
    drive_beat(5, 0, 0, 0);
    compared++; if (out_data !== pack_out(5, 0, 0, 0)) begin mismatched++; $display("FAIL bp_first: got %h want %h", out_data, pack_out(5, 0, 0, 0)); end
    in_valid = 1'b1; in_data = pack_in(9, 0, 0, 0);
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, out_valid); end
      compared++; if (out_data !== pack_out(5, 0, 0, 0)) begin mismatched++; $display("FAIL bp_hold_data[%0d]: got %h want %h", k, out_data, pack_out(5, 0, 0, 0)); end
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", k, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_ready_high: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_swap_valid: got %b want 1", out_valid); end
    compared++; if (out_data !== pack_out(9, 0, 0, 0)) begin mismatched++; $display("FAIL bp_swap_data: got %h want %h", out_data, pack_out(9, 0, 0, 0)); end
    idle_cycle();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    // Length change inside a group must not shorten it.
    cfg_len = 8'd3;
    drive_beat(1, 0, 0, 0);
    cfg_len = 8'd1;
    drive_beat(2, 0, 0, 0);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_cfg_midgroup: got %b want 0", out_valid); end
    drive_beat(3, 0, 0, 0);
    compared++; if (out_data !== pack_out(6, 0, 0, 0)) begin mismatched++; $display("FAIL bp_cfg_result: got %h want %h", out_data, pack_out(6, 0, 0, 0)); end
  endtask

  task automatic test_reset_mid();
    idle_cycle();
    cfg_len = 8'd3; cfg_mode = 2'd0;
    drive_beat(100, 0, 0, 0);
    drive_beat(100, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    drive_beat(1, 0, 0, 0);
    drive_beat(2, 0, 0, 0);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rmid_early: got %b want 0", out_valid); end
    drive_beat(3, 0, 0, 0);
    compared++; if (out_data !== pack_out(6, 0, 0, 0)) begin mismatched++; $display("FAIL rmid_data: got %h want %h", out_data, pack_out(6, 0, 0, 0)); end
  endtask

  task automatic test_back_to_back();
    idle_cycle();
    cfg_len = 8'd1; cfg_mode = 2'd3;
    drive_beat(-5, 1, 2, 3);
    compared++; if (out_data !== pack_out(-5, 1, 2, 3)) begin mismatched++; $display("FAIL b2b_mode3: got %h want %h", out_data, pack_out(-5, 1, 2, 3)); end
    cfg_mode = 2'd1;
    drive_beat(-5, 1, 2, 3);
    compared++; if (out_data !== pack_out(0, 1, 2, 3)) begin mismatched++; $display("FAIL b2b_relu: got %h want %h", out_data, pack_out(0, 1, 2, 3)); end
    compared++; if (out_sign !== 4'b0001) begin mismatched++; $display("FAIL b2b_relu_sign: got %b want 0001", out_sign); end
    cfg_mode = 2'd0;
    drive_beat(200, -200, 0, 0);
    compared++; if (out_ovf !== 4'b0011) begin mismatched++; $display("FAIL b2b_out_ovf: got %b want 0011", out_ovf); end
    compared++; if (out_data !== pack_out(127, -128, 0, 0)) begin mismatched++; $display("FAIL b2b_out_sat: got %h want %h", out_data, pack_out(127, -128, 0, 0)); end
    // Gaps in in_valid leave the partial group intact.
    cfg_len = 8'd2;
    drive_beat(10, 0, 0, 0);
    idle_cycle();
    idle_cycle();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL gap_valid: got %b want 0", out_valid); end
    drive_beat(20, 0, 0, 0);
    compared++; if (out_data !== pack_out(30, 0, 0, 0)) begin mismatched++; $display("FAIL gap_data: got %h want %h", out_data, pack_out(30, 0, 0, 0)); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_len = '0; cfg_mode = '0; out_ready = 1'b1;
    test_reset();
    test_relu();
    test_sign();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
